// File: rtl/demux_deser_pkg.sv
// Shared types and defaults for the demux-based serial-to-parallel receiver.
// Optional feature macro: DEMUX_DESER_PARITY_EN (adds the trailing parity bit).
package demux_deser_pkg;

    // Default parallel word width.
    localparam int DEMUX_DESER_WIDTH = 16;

    // Receiver FSM states; PARITY is only reachable when the parity bit is enabled.
    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        PARITY  = 2'd1,
        HOLD    = 2'd2
    } state_t;

    // Select/counter width for a given word width (never below one bit).
    function automatic int sel_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/demux_deser16_onehot_dec.sv
// SEL_W-to-WIDTH one-hot decoder with enable; produces the per-bit write strobes
// that steer the serial bit into its slot of the word register.
module onehot_dec
    import demux_deser_pkg::*;
#(
    parameter int SEL_W = 4,
    parameter int WIDTH = DEMUX_DESER_WIDTH
) (
    input  logic             en,
    input  logic [SEL_W-1:0] w,
    output logic [WIDTH-1:0] y
);

    // Exactly one output high (at index w) while enabled, all low otherwise.
    always_comb begin
        y = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (en && (w == SEL_W'(i))) begin
                y[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_deser16.sv
// Serial-to-parallel receiver: a select counter walks a 1-to-WIDTH demux that
// writes each accepted serial bit (LSB first) into the word register; the
// finished word is offered on a valid/ready output.
// Optional feature macro: DEMUX_DESER_PARITY_EN -- an even-parity bit follows
// each word and a mismatch is flagged on parity_err.
module demux_deser16
    import demux_deser_pkg::*;
#(
    parameter  int WIDTH = DEMUX_DESER_WIDTH,
    localparam int SEL_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_din,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [SEL_W-1:0] sel,
    output logic             parity_err
);

    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic             live;       // low while in reset and for the cycle it is sampled
    logic             bit_acc;
    logic             wr_en;
    logic [WIDTH-1:0] bit_we;

    assign dout_valid = (state == HOLD);
    assign bit_acc    = s_valid && s_ready;

    // Write strobes only where a data bit lands: COLLECT, or HOLD while the old
    // word is consumed in the same cycle (that bit goes to position 0).
    assign wr_en = bit_acc && ((state == COLLECT) || ((state == HOLD) && dout_ready));

    onehot_dec #(
        .SEL_W (SEL_W),
        .WIDTH (WIDTH)
    ) u_dec (
        .en (wr_en),
        .w  (sel),
        .y  (bit_we)
    );

    // Next-state and s_ready decode; s_ready follows dout_ready only in HOLD.
    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        case (state)
            COLLECT: begin
                s_ready = live;
                if (s_valid && live && (sel == SEL_LAST)) begin
`ifdef DEMUX_DESER_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = HOLD;
`endif
                end
            end
`ifdef DEMUX_DESER_PARITY_EN
            PARITY: begin
                s_ready = live;
                if (s_valid && live) begin
                    state_next = HOLD;
                end
            end
`endif
            HOLD: begin
                s_ready = live && dout_ready;
                if (dout_ready) begin
                    state_next = COLLECT;
                end
            end
            default: begin
                state_next = COLLECT;
            end
        endcase
    end

    // FSM state register and post-reset enable flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= COLLECT;
            live  <= 1'b0;
        end else begin
            state <= state_next;
            live  <= 1'b1;
        end
    end

    // Demux select: advances on each stored data bit, wraps after the last one.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel <= '0;
        end else if (bit_acc) begin
            case (state)
                COLLECT: sel <= (sel == SEL_LAST) ? '0 : sel + SEL_W'(1);
                HOLD:    sel <= SEL_W'(1);
                default: sel <= sel;
            endcase
        end
    end

    // Word register: only the strobed bit is rewritten; no clear between words.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (bit_we[i]) begin
                    dout[i] <= s_din;
                end
            end
        end
    end

`ifdef DEMUX_DESER_PARITY_EN
    logic parity_q;

    // Parity check captured with the parity bit, held until the next word completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else if ((state == PARITY) && bit_acc) begin
            parity_q <= (^dout) ^ s_din;
        end
    end

    assign parity_err = parity_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: doc/demux_deser16.md
# demux_deser16

Serial-to-parallel receiver: accepts one bit per handshake on a serial valid/ready input. A select counter drives a 1-to-N demultiplexer that steers each bit into its position of an N-bit word register. The completed word is presented on a parallel valid/ready output. It is the receiving end of a mux-based serializer: the serializer's select counter walks its 16-to-1 mux over `sel` = 0..15, and this block walks the demux over the same sequence, LSB first.

## Interface
- `WIDTH`, 16, parallel word width in bits; must be ≥ 2.
- `SEL_W`, $clog2(WIDTH), select/counter width; derived, never overridden.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `s_din`  in  1  serial data bit.
- `s_valid`  in  1  `s_din` is valid this cycle.
- `s_ready`  out  1  the block accepts a bit this cycle.
- `dout`  out  WIDTH  assembled word; meaningful only while `dout_valid` = 1.
- `dout_valid`  out  1  a complete word is held.
- `dout_ready`  in  1  the downstream consumer takes the word this cycle.
- `sel`  out  SEL_W  current demux select, i.e. the bit index of the next accepted bit.
- `parity_err`  out  1  parity mismatch on the held word; qualified by `dout_valid`.

## Operation
- Bit accept: `s_valid && s_ready`. Word accept: `dout_valid && dout_ready`.
- FSM states:
  - COLLECT: accepting bits.
  - PARITY: waiting for the parity bit; exists only with the macro.
  - HOLD: word complete, waiting for the consumer.
- COLLECT:
  - `s_ready` = 1.
  - On a bit accept, write `dout[sel]` = `s_din`. The write enable comes from one-hot decode of `sel`, and no other bit of `dout` changes.
  - On the same accept, `sel` increments.
  - On the accept with `sel` = WIDTH-1: `sel` wraps to 0 and the FSM goes to HOLD (or to PARITY when the macro is defined).
- HOLD:
  - `dout_valid` = 1 and `s_ready` = `dout_ready`.
  - On a word accept, return to COLLECT.
  - If a bit accept happens in the same cycle, that bit is written to `dout[0]` and `sel` becomes 1. This is legal because the old word is consumed in that cycle.
- Without a word accept, `dout` and `dout_valid` stay stable. No bit is lost or overwritten.
- `dout` is not cleared between words. Every bit is rewritten before the next `dout_valid`.
- Reset mid-word discards the partial word: `sel` goes to 0 and the FSM to COLLECT.
- `s_valid` = 0 in any state: no state change.

## Timing
- Reset values: `s_ready`=0 during `rst`, then 1 the cycle after deassertion. `dout_valid`=0, `dout`=0, `sel`=0, `parity_err`=0, FSM=COLLECT.
- Latency: `dout_valid` rises the cycle after the accept of the last bit (data bit WIDTH-1, or the parity bit with the macro).
- Throughput:
  - With `dout_ready` tied high, one word every WIDTH cycles (WIDTH+1 with the macro).
  - There is no bubble between words.
- `s_ready` depends combinationally on `dout_ready` in HOLD only. There are no other combinational input-to-output paths.

## Configuration
- Macro: `DEMUX_DESER_PARITY_EN`.
- Defined:
  - After data bit WIDTH-1, the FSM enters PARITY with `s_ready` = 1.
  - The next accepted bit is an even-parity bit and is not stored in `dout`.
  - `parity_err` = `^dout ^ parity_bit`. It is registered on entry to HOLD and held until the word accept.
  - `sel` stays 0 during PARITY.
- Undefined:
  - The PARITY state and parity logic are absent.
  - `parity_err` is tied to 0; the port always exists.

## Structure
- Package `demux_deser_pkg`:
  - FSM state enum: COLLECT, PARITY, HOLD.
  - Default width localparam: 16.
- One sub-module, `onehot_dec`: a parameterized SEL_W-to-WIDTH one-hot decoder with an enable (`en`, `w`, `y`). `y` = 0 when `en` = 0. It generates the per-bit write enables with `en` = bit accept in COLLECT, or in HOLD when `dout_ready` = 1.
- The FSM, counter and word register live in `demux_deser16`.

## Test plan
- Reset, then shift 16 bits of 0xA5C3 LSB first with `s_valid` and `dout_ready` high -> `dout_valid`=1 exactly one cycle after bit 15, `dout`=0xA5C3, `sel`=0.
- Words 0x0001 then 0xFFFE back-to-back with `dout_ready` high -> no idle cycle between words, and each word is correct on its `dout_valid` cycle.
- `dout_ready`=0 for 5 cycles after a word completes, with `s_valid` held high -> `s_ready`=0, `dout` stable. The first bit of the next word is accepted in the `dout_ready` cycle.
- Assert `rst` after 7 bits of 0x00FF -> `sel`=0, `dout_valid`=0. Next, send a full word 0x1234 -> `dout`=0x1234.
- Gap stimulus with `s_valid` toggling 1/0 every cycle while sending 0x8001 -> `dout`=0x8001 after 32 cycles, `sel` counting only on accepts.
- With `DEMUX_DESER_PARITY_EN`: send 0x0003 + parity 0 -> `parity_err`=0. Send 0x0007 + parity 0 -> `parity_err`=1, held until `dout_ready`.
